// File: rtl/barcode_stim_gen.sv
// Pulse-width barcode serialiser: start cell, MSB-first ID cells, optional parity, repeated frames with gaps.
// Registered outputs, BC falls one edge after an accepted send; send is ignored while busy, abort returns to idle.
module barcode_stim_gen #(
  parameter int ID_W      = 8,
  parameter int PER_W     = 22,
  parameter int PARITY    = 0,
  parameter int GAP_CELLS = 4,
  parameter int MIN_PER   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [ID_W-1:0]  station_ID,
  input  logic [PER_W-1:0] period,
  input  logic [3:0]       reps,
  input  logic             abort,
  output logic             BC,
  output logic             busy,
  output logic             BC_done
);

  localparam int BI_W = $clog2(ID_W + 2);
  localparam int GW   = (GAP_CELLS > 1) ? $clog2(GAP_CELLS) : 1;
  localparam logic [BI_W-1:0]  LAST_IDX = BI_W'(ID_W + ((PARITY != 0) ? 1 : 0));
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CELLS > 0) ? GAP_CELLS - 1 : 0);
  localparam logic [PER_W-1:0] PER_MIN  = PER_W'(MIN_PER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [BI_W-1:0]  bit_idx_q, bit_idx_d;
  logic [3:0]       rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             bc_q, bc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cur_bit;
  logic [PER_W-1:0] quarter;
  logic [PER_W-1:0] low_len;
  logic [PER_W-1:0] cnt_nxt;
  logic             cell_end;

  // Cell index 0 is the start cell, 1..ID_W carry the ID MSB first, ID_W+1 is parity.
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < ID_W; i++) begin
      if (bit_idx_q == BI_W'(ID_W - i)) cur_bit = id_q[i];
    end
    if (PARITY != 0 && bit_idx_q == LAST_IDX) begin
      cur_bit = (PARITY == 1) ? ^id_q : ~^id_q;
    end
  end

  always_comb begin
    quarter  = per_q >> 2;
    cnt_nxt  = cnt_q + PER_W'(1);
    cell_end = (cnt_q == per_q - PER_W'(1));
    if (bit_idx_q == '0) begin
      low_len = per_q >> 1;
    end else if (cur_bit) begin
      low_len = quarter;
    end else begin
      low_len = quarter + (quarter << 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    per_d     = per_q;
    id_d      = id_q;
    bc_d      = bc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (send && !abort) begin
          state_d   = S_LOW;
          cnt_d     = '0;
          bit_idx_d = '0;
          gap_d     = '0;
          rep_d     = (reps == 4'd0) ? 4'd1 : reps;
          per_d     = (period < PER_MIN) ? PER_MIN : period;
          id_d      = station_ID;
          bc_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_LOW: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt == low_len) begin
          state_d = S_HIGH;
          bc_d    = 1'b1;
        end
      end
      S_HIGH: begin
        cnt_d = cnt_nxt;
        if (cell_end) begin
          cnt_d = '0;
          if (bit_idx_q != LAST_IDX) begin
            bit_idx_d = bit_idx_q + BI_W'(1);
            state_d   = S_LOW;
            bc_d      = 1'b0;
          end else if (rep_q > 4'd1) begin
            rep_d     = rep_q - 4'd1;
            bit_idx_d = '0;
            gap_d     = '0;
            if (GAP_CELLS == 0) begin
              state_d = S_LOW;
              bc_d    = 1'b0;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_nxt;
        if (cell_end) begin
          cnt_d = '0;
          if (gap_q == GAP_LAST) begin
            state_d = S_LOW;
            bc_d    = 1'b0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bc_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
      gap_d     = '0;
      bc_d      = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      per_q     <= '0;
      id_q      <= '0;
      bc_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      per_q     <= per_d;
      id_q      <= id_d;
      bc_q      <= bc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BC      = bc_q;
  assign busy    = busy_q;
  assign BC_done = done_q;

endmodule
